// File: rtl/m_7seg_pkg.sv
// Shared 7-segment constants: active-low patterns for bits g..a, the DP bit
// position and the nibble reported for a dark digit.
package m_7seg_pkg;

  localparam int unsigned SEG_W  = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DP_BIT = 7;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_9_ALT = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BLANK_NIBBLE = 4'hF;

endpackage

// File: rtl/m_7seg_pattern_decode.sv
// Combinational reverse lookup of an active-low 7-segment pattern to BCD,
// flagging dark digits and patterns that are not part of the driver's table.
module m_7seg_pattern_decode
  import m_7seg_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] digit_c,
  output logic       blank_c,
  output logic       illegal_c
);

  always_comb begin
    digit_c   = 4'd0;
    blank_c   = 1'b0;
    illegal_c = 1'b0;
    case (pat)
      SEG_0:            digit_c = 4'd0;
      SEG_1:            digit_c = 4'd1;
      SEG_2:            digit_c = 4'd2;
      SEG_3:            digit_c = 4'd3;
      SEG_4:            digit_c = 4'd4;
      SEG_5:            digit_c = 4'd5;
      SEG_6:            digit_c = 4'd6;
      SEG_7:            digit_c = 4'd7;
      SEG_8:            digit_c = 4'd8;
      SEG_9, SEG_9_ALT: digit_c = 4'd9;
      SEG_BLANK: begin
        digit_c = BLANK_NIBBLE;
        blank_c = 1'b1;
      end
      default:          illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/m_7seg_capture.sv
// Monitors a multiplexed active-low 7-segment bus, debounces each digit slot
// and publishes the reconstructed multi-digit value once a full scan is seen.
module m_7seg_capture
  import m_7seg_pkg::*;
#(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned STABLE  = 3,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEG_W-1:0]      seg_n,
  input  logic [DIGITS-1:0]     dig_n,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     blank,
  output logic                  valid,
  output logic                  err,
  output logic                  stale
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [SEG_W-1:0]    s_seg_q, s_seg_d;
  logic [DIGITS-1:0]   s_dig_q, s_dig_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [4*DIGITS-1:0] sh_val_q, sh_val_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [TW-1:0]       to_q, to_d;
  logic                stale_q, stale_d;

  logic [3:0] digit_c;
  logic       dec_blank_c;
  logic       illegal_c;
  logic       one_hot_c;
  logic       same_c;
  logic       accept_c;
  logic       commit_c;

  m_7seg_pattern_decode u_decode (
    .pat       (seg_n[6:0]),
    .digit_c   (digit_c),
    .blank_c   (dec_blank_c),
    .illegal_c (illegal_c)
  );

  always_comb begin
    s_seg_d    = seg_n;
    s_dig_d    = dig_n;
    cnt_d      = cnt_q;
    seen_d     = seen_q;
    sh_val_d   = sh_val_q;
    sh_dp_d    = sh_dp_q;
    sh_blank_d = sh_blank_q;
    value_d    = value_q;
    dp_d       = dp_q;
    blank_d    = blank_q;
    valid_d    = 1'b0;
    err_d      = err_q;
    to_d       = to_q;

    one_hot_c = $onehot(~dig_n);
    same_c    = (seg_n == s_seg_q) && (dig_n == s_dig_q);

    // Run length of identical one-hot samples, saturating at STABLE.
    if (one_hot_c && same_c) begin
      cnt_d = (cnt_q < CNT_W'(STABLE)) ? cnt_q + CNT_W'(1) : CNT_W'(STABLE);
    end else begin
      cnt_d = one_hot_c ? CNT_W'(1) : CNT_W'(0);
    end
    // Accept only on the edge the run first reaches STABLE.
    accept_c = one_hot_c && (cnt_d == CNT_W'(STABLE)) &&
               ((cnt_q != CNT_W'(STABLE)) || !same_c);
    commit_c = &seen_q;

    if (commit_c) begin
      value_d = sh_val_q;
      dp_d    = sh_dp_q;
      blank_d = sh_blank_q;
      valid_d = 1'b1;
      seen_d  = '0;
      to_d    = '0;
    end else if (to_q != TW'(TIMEOUT)) begin
      to_d = to_q + TW'(1);
    end

    if (accept_c && illegal_c) begin
      err_d = 1'b1;
    end
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (accept_c && !illegal_c && !dig_n[i]) begin
        sh_val_d[4*i +: 4] = digit_c;
        sh_dp_d[i]         = ~seg_n[DP_BIT];
        sh_blank_d[i]      = dec_blank_c;
        seen_d[i]          = 1'b1;
      end
    end

    if (clear) begin
      seen_d = '0;
      err_d  = 1'b0;
      to_d   = '0;
    end
    stale_d = (to_d == TW'(TIMEOUT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_seg_q    <= '1;
      s_dig_q    <= '1;
      cnt_q      <= '0;
      seen_q     <= '0;
      sh_val_q   <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '0;
      value_q    <= '0;
      dp_q       <= '0;
      blank_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      to_q       <= '0;
      stale_q    <= 1'b0;
    end else begin
      s_seg_q    <= s_seg_d;
      s_dig_q    <= s_dig_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      sh_val_q   <= sh_val_d;
      sh_dp_q    <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
      value_q    <= value_d;
      dp_q       <= dp_d;
      blank_q    <= blank_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      to_q       <= to_d;
      stale_q    <= stale_d;
    end
  end

  assign value = value_q;
  assign dp    = dp_q;
  assign blank = blank_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign stale = stale_q;

endmodule
